// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned SEQ_DET_MAX_LEN_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_UNCFG,
    S_FILL,
    S_RUN
  } seq_det_state_t;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes priority.
module seq_det_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable serial bit-pattern detector with match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = SEQ_DET_MAX_LEN_DEFAULT,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_mealy,
  output logic               cfg_err,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  seq_det_state_t state_q, state_d;

  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic               mealy_q;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               armed_q;
  logic               cfg_err_q;
  logic               match_q;

  logic               cfg_ok_c;
  logic               fill_ok_c;
  logic [MAX_LEN-1:0] shifted_c;
  logic [MAX_LEN-1:0] mask_c;
  logic               hit_c;

  // Hit detection against the low len_q bits of history plus the new bit.
  always_comb begin
    cfg_ok_c  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    shifted_c = {hist_q, in_bit};
    mask_c    = ~({MAX_LEN{1'b1}} << len_q);
    fill_ok_c = ({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q};
    hit_c     = in_valid && !cfg_load && (state_q != S_UNCFG) && fill_ok_c &&
                (((shifted_c ^ pat_q) & mask_c) == '0);
  end

  // Next-state: a load wins over the stream bit; non-overlap hits restart the fill.
  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (cfg_load) begin
      if (cfg_ok_c) begin
        state_d = S_FILL;
        hist_d  = '0;
        fill_d  = '0;
      end
    end else if (in_valid && (state_q != S_UNCFG)) begin
      if (hit_c && !overlap_q) begin
        state_d = S_FILL;
        hist_d  = '0;
        fill_d  = '0;
      end else begin
        hist_d  = shifted_c[MAX_LEN-2:0];
        fill_d  = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
        state_d = (fill_d == len_q) ? S_RUN : S_FILL;
      end
    end
  end

  // FSM state, history and fill count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_UNCFG;
      hist_q  <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
    end
  end

  // Configuration registers, updated only by a legal load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      mealy_q   <= 1'b0;
    end else if (cfg_load && cfg_ok_c) begin
      pat_q     <= cfg_pat;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
      mealy_q   <= cfg_mealy;
    end
  end

  // Registered status flags and Moore match; a load forces hit_c low, clearing match_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      armed_q   <= armed_q || (cfg_load && cfg_ok_c);
      cfg_err_q <= cfg_load && !cfg_ok_c;
      match_q   <= hit_c && !mealy_q;
    end
  end

  seq_det_sat_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cfg_load && cfg_ok_c),
    .inc (hit_c),
    .cnt (match_cnt)
  );

  assign match   = mealy_q ? hit_c : match_q;
  assign armed   = armed_q;
  assign cfg_err = cfg_err_q;

endmodule
